// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: state encoding and default timing shared by UART TX and RX  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int unsigned DEFAULT_COUNTER_SIZE = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
  localparam int unsigned DEFAULT_NUM_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_baud_counter.sv
// +----------------------------------------------------------------------+
// | baud_counter: per-bit clock counter, wraps every CLKS_PER_BIT cycles  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module baud_counter #(
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  output logic [COUNTER_SIZE-1:0] count,
  output logic                    tick
);

  localparam logic [COUNTER_SIZE-1:0] LAST_COUNT = COUNTER_SIZE'(CLKS_PER_BIT - 1);

  logic [COUNTER_SIZE-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST_COUNT) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tick  = (count_q == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// +----------------------------------------------------------------------+
// | uart_tx: 8N1 serial transmitter, one parallel word per handshake      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE          = DEFAULT_COUNTER_SIZE,
  parameter int unsigned CLKS_PER_BIT          = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned NUM_OF_BITS_IN_BUFFER = DEFAULT_NUM_BITS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_OF_BITS_IN_BUFFER-1:0] data,
  input  logic                             start,
  output logic                             ready,
  output logic                             out,
  output logic                             done
);

  localparam logic [3:0]              LAST_BIT   = 4'(NUM_OF_BITS_IN_BUFFER - 1);
  localparam logic [COUNTER_SIZE-1:0] LAST_COUNT = COUNTER_SIZE'(CLKS_PER_BIT - 1);

  uart_state_e                      state_q, state_d;
  logic [NUM_OF_BITS_IN_BUFFER-1:0] shift_q, shift_d;
  logic [3:0]                       bit_idx_q, bit_idx_d;
  logic                             out_q, out_d;
  logic                             accept;
  logic                             baud_enable;
  logic                             baud_tick;
  logic [COUNTER_SIZE-1:0]          baud_count;

  assign accept      = (state_q == IDLE) && start;
  assign baud_enable = (state_q != IDLE);

  baud_counter #(
    .COUNTER_SIZE (COUNTER_SIZE),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (baud_enable),
    .count  (baud_count),
    .tick   (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = data;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so the flop leads the FSM by nothing
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
      default: out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      out_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      out_q     <= out_d;
    end
  end

  assign out   = out_q;
  assign ready = (state_q == IDLE);
  assign done  = (state_q == STOP) && (baud_count == LAST_COUNT);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx: scoreboard bench with a serial receiver model             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx;

  logic       clock;
  logic       reset;
  logic [7:0] data4, data2;
  logic       start4, start2;
  logic       ready4, ready2;
  logic       out4, out2;
  logic       done4, done2;

  int n_vec;
  int n_err;
  logic [7:0] sb_q[$];

  uart_tx #(.COUNTER_SIZE(8), .CLKS_PER_BIT(4), .NUM_OF_BITS_IN_BUFFER(8)) dut4 (
    .clock (clock), .reset (reset), .data (data4), .start (start4),
    .ready (ready4), .out (out4), .done (done4)
  );

  uart_tx #(.COUNTER_SIZE(8), .CLKS_PER_BIT(217), .NUM_OF_BITS_IN_BUFFER(8)) dut217 (
    .clock (clock), .reset (reset), .data (data2), .start (start2),
    .ready (ready2), .out (out2), .done (done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Receiver model: samples mid-bit, drops any frame touched by reset
  task automatic rx_frame();
    logic       aborted;
    logic [7:0] b;
    logic       stop_bit;
    aborted = 1'b0;
    b       = '0;
    @(negedge clock);
    aborted |= ~reset;
    if (!aborted) check("rx_start_bit", out4, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) begin
        @(negedge clock);
        aborted |= ~reset;
      end
      b[i] = out4;
    end
    repeat (4) begin
      @(negedge clock);
      aborted |= ~reset;
    end
    stop_bit = out4;
    if (!aborted) begin
      check("rx_stop_bit", stop_bit, 1);
      if (sb_q.size() == 0) begin
        check("rx_extra_frame", {24'h0, b}, 32'hFFFF_FFFF);
      end else begin
        check("rx_byte", b, sb_q.pop_front());
      end
    end
  endtask

  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && prev === 1'b1 && out4 === 1'b0) rx_frame();
      prev = (reset === 1'b1) ? out4 : 1'b1;
    end
  end

  // Drives a one-cycle request; returns at the first sample after acceptance
  task automatic send4(input logic [7:0] d, input bit push);
    @(negedge clock);
    data4  = d;
    start4 = 1'b1;
    if (push) sb_q.push_back(d);
    @(negedge clock);
    start4 = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (out4 !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  initial begin
    logic [7:0] lb [4];
    logic [7:0] pat;
    logic       exp_bit;
    int         lows, highs, done_at, low_in_rst;

    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start4 = 1'b0;
    data4  = '0;
    start2 = 1'b0;
    data2  = '0;

    // Asynchronous reset before any clock edge
    #3 reset = 1'b0;
    #1;
    check("rst_out", out4, 1);
    check("rst_ready", ready4, 1);
    check("rst_done", done4, 0);
    check("rst_out217", out2, 1);
    start4 = 1'b1;
    data4  = 8'hAA;
    low_in_rst = 0;
    repeat (5) begin
      @(negedge clock);
      if (out4 !== 1'b1 || ready4 !== 1'b1) low_in_rst++;
    end
    check("rst_hold_no_frame", low_in_rst, 0);

    // Single byte A5, first acceptance on first edge after release
    pat = 8'hA5;
    reset  = 1'b1;
    data4  = pat;
    sb_q.push_back(pat);
    for (int c = 1; c <= 41; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start4 = 1'b0;
        check("a5_ready_low", ready4, 0);
      end
      if (c <= 40) begin
        if ((c - 1) / 4 == 0)      exp_bit = 1'b0;
        else if ((c - 1) / 4 == 9) exp_bit = 1'b1;
        else                       exp_bit = pat[(c - 1) / 4 - 1];
        check($sformatf("a5_out_c%0d", c), out4, exp_bit);
        check($sformatf("a5_done_c%0d", c), done4, (c == 40) ? 1 : 0);
      end else begin
        check("a5_ready_after", ready4, 1);
        check("a5_done_after", done4, 0);
      end
    end

    // Back-to-back with start held, data changed mid-frame
    @(negedge clock);
    data4  = 8'hFF;
    start4 = 1'b1;
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'h01);
    @(negedge clock);
    data4 = 8'h01;
    repeat (39) @(negedge clock);
    check("b2b_done1", done4, 1);
    @(negedge clock);
    check("b2b_gap_out", out4, 1);
    check("b2b_gap_ready", ready4, 1);
    @(negedge clock);
    check("b2b_second_start", out4, 0);
    check("b2b_second_ready", ready4, 0);
    data4 = 8'h77;
    repeat (10) @(negedge clock);
    start4 = 1'b0;
    repeat (30) @(negedge clock);
    idle_check("b2b_no_third", 20);

    // Request during DATA is ignored
    send4(8'h0F, 1'b1);
    repeat (9) @(negedge clock);
    data4  = 8'h3C;
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    repeat (30) @(negedge clock);
    check("ign_ready", ready4, 1);
    idle_check("ign_no_extra", 30);

    // Reset in data bit 3 of 55
    send4(8'h55, 1'b0);
    repeat (17) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_out", out4, 1);
    check("midrst_ready", ready4, 1);
    check("midrst_done", done4, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    idle_check("midrst_stays_idle", 25);

    // Loopback through the receiver model
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      send4(lb[k], 1'b1);
      repeat (40) @(negedge clock);
    end

    // Default timing on the 217-clock instance
    @(negedge clock);
    data2  = 8'h00;
    start2 = 1'b1;
    @(negedge clock);
    start2  = 1'b0;
    lows    = 0;
    highs   = 0;
    done_at = 0;
    for (int c = 1; c <= 2300 && done_at == 0; c++) begin
      if (c > 1) @(negedge clock);
      if (out2 === 1'b0 && highs == 0) lows++;
      else if (out2 === 1'b1)          highs++;
      if (done2 === 1'b1) done_at = c;
    end
    check("t217_low_cycles", lows, 1953);
    check("t217_high_cycles", highs, 217);
    check("t217_done_cycle", done_at, 2170);
    @(negedge clock);
    check("t217_ready_after", ready2, 1);

    repeat (10) @(negedge clock);
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
